carry_skip_add_sequencer: RTL and testbench
===========================================

CARRY_SKIP_ADD_SEQUENCER -- requirements
Module: carry_skip_add_sequencer

Interface
REQ-001 Parameter BLOCK_SIZE, default 2: skip-block width passed to the adder slice.
REQ-002 Parameter N, default 4: slice width in bits, passed to the adder slice; N SHALL be a multiple of BLOCK_SIZE.
REQ-003 Parameter WORDS, default 4: slices per operation; WORDS >= 1; W = N*WORDS.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  request carries a valid operand set.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 a  input  W  operand A.
REQ-010 b  input  W  operand B.
REQ-011 cin  input  1  carry in to the least significant slice.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  W  (a + b + cin) mod 2^W.
REQ-015 cout  output  1  carry out of the most significant slice.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; on in_valid=1 the block SHALL register a, b, cin, clear the slice index, set the carry register to cin, and go to RUN.
REQ-019 RUN: each cycle, slice idx (bits idx*N+N-1 : idx*N) of the registered a and b plus the carry register SHALL feed the adder slice. The slice sum SHALL be written to the same bits of the sum register. The slice cout SHALL be written to the carry register. idx SHALL then increment.
REQ-020 RUN -> DONE on the cycle that processes idx = WORDS-1; with WORDS=1 this is the first RUN cycle.
REQ-021 DONE: out_valid=1; sum and cout SHALL hold stable until out_ready=1 is sampled, then the FSM goes to IDLE.
REQ-022 Latency: accept at edge k -> out_valid high after edge k+WORDS; throughput is one operation per WORDS+2 cycles minimum.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and no operand register SHALL change.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 The sum register bits not yet written in RUN SHALL be undefined-free: cleared to 0 on accept.
REQ-026 cout SHALL equal the carry register when in DONE. Overflow wraps modulo 2^W with no other flag.
REQ-027 The slice index SHALL be ceil(log2(WORDS)) bits wide, minimum 1. The slice index SHALL never exceed WORDS-1.

Reset
REQ-028 On rst_n=0, at any time including mid-RUN or in DONE, the block SHALL abort, go to IDLE, and clear idx, the carry register, the operand registers, sum and cout.
REQ-029 Output values during reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-030 After reset release, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE/RUN/DONE) and the index-width function.
REQ-032 The block SHALL instantiate exactly one carry_skip_adder with parameters BLOCK_SIZE and N as its datapath sub-module. It SHALL contain no other adder.

Verification (defaults N=4, BLOCK_SIZE=2, WORDS=4, W=16)
REQ-033 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; out_valid rises exactly 4 cycles after accept.
REQ-034 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; in_valid pulsed during RUN is ignored and the result is unchanged.
REQ-035 Result with out_ready=0 for 5 cycles -> sum and cout stable, out_valid held. With out_ready=1, the FSM returns to IDLE and in_ready=1 the next cycle.
REQ-036 Assert rst_n=0 after 2 RUN cycles -> immediately out_valid=0, busy=0, in_ready=1. The next request a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0.
REQ-037 WORDS=1, N=1, BLOCK_SIZE=1 build: all 8 combinations of a, b, cin -> sum and cout equal the 1-bit full-adder truth table; latency is 1 cycle.
REQ-038 Random back-to-back regression of 1000 operations with random out_ready stalls -> every result matches the reference model (a+b+cin), with no lost or duplicated transaction.

Source files
------------

// File: rtl/carry_skip_add_sequencer_pkg.sv
// Shared definitions for the carry-skip add sequencer: the control state
// encoding and the helper that sizes the slice index.
package carry_skip_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count slices 0..words-1, never less than one bit.
    function automatic int idx_width(input int words);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/carry_skip_add_sequencer_adder.sv
// Combinational N-bit carry-skip adder. Bits ripple inside each block of
// BLOCK_SIZE bits; when every bit of a block propagates, the block's
// carry-in bypasses the ripple chain and becomes the block's carry-out.
// N must be a multiple of BLOCK_SIZE.
module carry_skip_adder #(
    parameter int BLOCK_SIZE = 2,
    parameter int N          = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NB = N / BLOCK_SIZE;

    logic [N-1:0] w_p;
    logic [N-1:0] w_g;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pg
            assign w_p[gi] = a[gi] ^ b[gi];
            assign w_g[gi] = a[gi] & b[gi];
        end
    endgenerate

    // Walk the blocks LSB first: ripple inside a block, skip across it when
    // the whole block propagates.
    always_comb begin
        logic w_blk_c;
        logic w_rip_c;
        logic w_p_all;
        sum     = '0;
        w_blk_c = cin;
        w_rip_c = 1'b0;
        w_p_all = 1'b1;
        for (int j = 0; j < NB; j++) begin
            w_rip_c = w_blk_c;
            w_p_all = 1'b1;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                sum[j*BLOCK_SIZE + k] = w_p[j*BLOCK_SIZE + k] ^ w_rip_c;
                w_rip_c = w_g[j*BLOCK_SIZE + k] | (w_p[j*BLOCK_SIZE + k] & w_rip_c);
                w_p_all = w_p_all & w_p[j*BLOCK_SIZE + k];
            end
            w_blk_c = w_p_all ? w_blk_c : w_rip_c;
        end
        cout = w_blk_c;
    end

endmodule

// File: rtl/carry_skip_add_sequencer.sv
// Multi-cycle W-bit adder (W = N*WORDS). One N-bit carry-skip slice is
// reused once per word, least significant word first, with the carry held
// in a register between words. Valid/ready on both sides.
module carry_skip_add_sequencer
    import carry_skip_add_sequencer_pkg::*;
#(
    parameter int BLOCK_SIZE = 2,
    parameter int N          = 4,
    parameter int WORDS      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_cout;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [N-1:0]  w_a_words [WORDS];
    logic [N-1:0]  w_b_words [WORDS];
    logic [N-1:0]  w_slice_a;
    logic [N-1:0]  w_slice_b;
    logic [N-1:0]  w_slice_sum;
    logic          w_slice_cout;
    logic [W-1:0]  w_sum_merged;

    // Split the operand registers into words and build the next sum value
    // with only the current word replaced by the slice result.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign w_a_words[gi] = r_a[gi*N +: N];
            assign w_b_words[gi] = r_b[gi*N +: N];
            assign w_sum_merged[gi*N +: N] =
                (r_idx == IW'(gi)) ? w_slice_sum : r_sum[gi*N +: N];
        end
    endgenerate

    assign w_slice_a = w_a_words[r_idx];
    assign w_slice_b = w_b_words[r_idx];

    carry_skip_adder #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .N          (N)
    ) u_adder (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_cout     <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_merged;
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        // Index stays at the last word so it never leaves range.
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_carry_skip_add_sequencer.sv
// Scoreboard bench: drivers push expected {cout,sum} and accept cycle into
// queues; per-DUT monitors compare whenever out_valid is presented.
module tb_carry_skip_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default build: N=4, BLOCK_SIZE=2, WORDS=4 (16 bits)
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [15:0] a, b, sum;
    logic        dir_ready, rnd_ready;
    bit          rand_stall = 1'b0;

    // Single-bit build: N=1, BLOCK_SIZE=1, WORDS=1
    logic        in_valid2, in_ready2, out_valid2, cin2, cout2, busy2;
    logic        out_ready2;
    logic [0:0]  a2, b2, sum2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] exp_q[$];
    int          lat_q[$];
    logic [1:0]  exp2_q[$];
    int          lat2_q[$];

    assign out_ready  = rand_stall ? rnd_ready : dir_ready;
    assign out_ready2 = 1'b1;

    carry_skip_add_sequencer #(.BLOCK_SIZE(2), .N(4), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    carry_skip_add_sequencer #(.BLOCK_SIZE(1), .N(1), .WORDS(1)) dut1b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_stall) begin
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
        checks++;
        if (act !== ev) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, ev, $time);
        end
    endtask

    // Monitor for the 16-bit build
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", exp_q.size(), 1);
                end else begin
                    chk("sum", sum, exp_q[0][15:0]);
                    chk("cout", cout, exp_q[0][16]);
                    chk("busy_done", busy, 1);
                    chk("in_ready_done", in_ready, 0);
                    if (!prev_valid && lat_q.size() > 0)
                        chk("latency", cyc - lat_q.pop_front(), 4);
                    if (out_ready) begin
                        $display("txn16 sum=%h cout=%b expected=%h", sum, cout, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Monitor for the single-bit build
    logic prev_valid2 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid2) begin
                if (exp2_q.size() == 0) begin
                    chk("unexpected_result1b", exp2_q.size(), 1);
                end else begin
                    chk("sum1b", sum2, exp2_q[0][0]);
                    chk("cout1b", cout2, exp2_q[0][1]);
                    if (!prev_valid2 && lat2_q.size() > 0)
                        chk("latency1b", cyc - lat2_q.pop_front(), 1);
                    $display("txn1b sum=%b cout=%b expected=%b", sum2, cout2, exp2_q[0]);
                    void'(exp2_q.pop_front());
                end
            end
            prev_valid2 = out_valid2;
        end else begin
            prev_valid2 = 1'b0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                         input logic [16:0] ev, input bit expect_result);
        int n;
        n = 0;
        a = ta; b = tbv; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", (n < 500), 1);
        if (expect_result) exp_q.push_back(ev);
        @(posedge clk); #1;
        if (expect_result) lat_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic issue2(input logic ta, input logic tbv, input logic tc, input logic [1:0] ev);
        int n;
        n = 0;
        a2 = ta; b2 = tbv; cin2 = tc; in_valid2 = 1'b1;
        while (!in_ready2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout1b", (n < 50), 1);
        exp2_q.push_back(ev);
        @(posedge clk); #1;
        lat2_q.push_back(cyc);
        in_valid2 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0 || !in_ready) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", (n < 3000), 1);
    endtask

    // 1-bit full-adder truth table indexed by {a,b,cin}: {cout,sum}
    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic        rc;
        logic [2:0]  v;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        dir_ready = 1'b1; rnd_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Wrap to zero with carry out
        issue(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, 1'b1);
        wait_drain();

        // Carry in; in_valid pulsed during RUN; 5-cycle output stall
        dir_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b1, 17'h0_5556, 1'b1);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("valid_timeout", (n < 50), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid_held", out_valid, 1);
        dir_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        wait_drain();

        // Reset after two RUN cycles aborts the operation
        issue(16'h5555, 16'h1111, 1'b0, 17'h0, 1'b0);
        @(posedge clk); #1;
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(16'h00FF, 16'h0001, 1'b0, 17'h0_0100, 1'b1);
        wait_drain();

        // Further hand-computed vectors
        issue(16'h8000, 16'h8000, 1'b1, 17'h1_0001, 1'b1);
        issue(16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000, 1'b1);
        issue(16'h7FFF, 16'h0000, 1'b1, 17'h0_8000, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, 1'b1);
        wait_drain();

        // Single-bit build: full-adder truth table, latency 1
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            issue2(v[2], v[1], v[0], fa_tab[i]);
        end
        wait_drain();

        // Back-to-back regression with random consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'b0, rc}, 1'b1);
        end
        wait_drain();
        rand_stall = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("scoreboard1b_empty", exp2_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
